fetch_next_pc: RTL and testbench

- Front-end PC generator that drives the fetch port of the pipelined 16-bit CPU, directly upstream of the Fetch 0/Fetch 1 stages.
- Holds the architectural fetch PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts the next fetch address every cycle.
- Accepts flush redirects and branch-outcome training from write-back.

---
 rtl/fetch_next_pc_if.sv | 27 ++
 rtl/fetch_next_pc.sv | 137 +++++++++++++
 tb/tb_fetch_next_pc.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_next_pc_if.sv
// rtl/fetch_next_pc_if.sv - fetch redirect/training inputs and next-PC prediction outputs
interface fetch_next_pc_if;
    logic        stall;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        pred_taken;
    logic [15:0] pred_next;

    modport slave (
        input  stall, halt, redirect, redirect_pc,
        input  upd_en, upd_pc, upd_taken, upd_target,
        output fetch_pc, fetch_valid, pred_taken, pred_next
    );

    modport master (
        output stall, halt, redirect, redirect_pc,
        output upd_en, upd_pc, upd_taken, upd_target,
        input  fetch_pc, fetch_valid, pred_taken, pred_next
    );
endinterface

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - fetch PC register with direct-mapped BTB and 2-bit counters
module fetch_next_pc #(
    parameter int          IDX_BITS = 10,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk_i,
    input  logic          reset_i,
    fetch_next_pc_if.slave bus_if
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 15 - IDX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [15:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic                rd_hit;
    logic                pred_taken;
    logic [15:0]         pc_plus2;
    logic [15:0]         pred_next;

    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]    wr_tag;
    logic                wr_hit;
    logic [1:0]          wr_ctr;
    logic [1:0]          ctr_nx;
    logic                wr_en;
    logic                unused_upd_lsb;

    assign unused_upd_lsb = bus_if.upd_pc[0];

    // Lookup reads only registered state, so a same-cycle update is never bypassed.
    assign rd_idx     = pc_q[IDX_BITS:1];
    assign rd_tag     = pc_q[15:IDX_BITS+1];
    assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken = rd_hit && ctr_q[rd_idx][1];
    assign pc_plus2   = pc_q + 16'd2;
    assign pred_next  = pred_taken ? target_q[rd_idx] : pc_plus2;

    assign bus_if.fetch_pc    = pc_q;
    assign bus_if.fetch_valid = (state_q == ST_RUN);
    assign bus_if.pred_taken  = pred_taken;
    assign bus_if.pred_next   = pred_next;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // The first cycle out of reset presents RESET_PC as the first real fetch,
    // so the PC only starts advancing once fetch_valid is up.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                    if (bus_if.redirect) begin
                        pc_d = bus_if.redirect_pc;
                    end
                end
            end
            ST_RUN: begin
                if (bus_if.halt) begin
                    state_d = ST_HALT;
                end else if (bus_if.redirect) begin
                    pc_d = bus_if.redirect_pc;
                end else if (!bus_if.stall) begin
                    pc_d = pred_next;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign wr_idx = bus_if.upd_pc[IDX_BITS:1];
    assign wr_tag = bus_if.upd_pc[15:IDX_BITS+1];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_ctr = ctr_q[wr_idx];

    always_comb begin
        ctr_nx = 2'b10;
        if (wr_hit) begin
            if (bus_if.upd_taken) begin
                ctr_nx = (wr_ctr == 2'b11) ? 2'b11 : wr_ctr + 2'd1;
            end else begin
                ctr_nx = (wr_ctr == 2'b00) ? 2'b00 : wr_ctr - 2'd1;
            end
        end
    end

    // A not-taken miss leaves the entry alone; a taken miss (incl. alias) reallocates.
    assign wr_en = bus_if.upd_en && !reset_i && (wr_hit || bus_if.upd_taken);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else if (bus_if.upd_en && bus_if.upd_taken) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ctr_q[wr_idx] <= ctr_nx;
            tag_q[wr_idx] <= wr_tag;
            if (bus_if.upd_taken) begin
                target_q[wr_idx] <= bus_if.upd_target;
            end
        end
    end
endmodule

// File: tb/tb_fetch_next_pc.sv
// tb/tb_fetch_next_pc.sv - directed and randomized bench for fetch_next_pc against a BTB model
module tb_fetch_next_pc;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_next_pc_if bus ();

    fetch_next_pc #(.IDX_BITS(10), .RESET_PC(16'h0000)) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: 1024-entry table, plain integer counters.
    bit          m_valid [1024];
    int          m_tag   [1024];
    logic [15:0] m_tgt   [1024];
    int          m_ctr   [1024];
    logic [15:0] m_pc    = 16'h0000;
    bit          m_fv     = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_known  = 1'b0;

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[10:1]] && (m_tag[a[10:1]] == int'(a[15:11]));
    endfunction

    function automatic bit m_ptaken(input logic [15:0] a);
        return m_hit(a) && (m_ctr[a[10:1]] >= 2);
    endfunction

    function automatic logic [15:0] m_pred(input logic [15:0] a);
        if (m_ptaken(a)) return m_tgt[a[10:1]];
        return a + 16'd2;
    endfunction

    always @(posedge clk) begin
        logic [15:0] nxt;
        int          ix;
        if (rst) begin
            m_pc     = 16'h0000;
            m_fv     = 1'b0;
            m_halted = 1'b0;
            m_known  = 1'b1;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else begin
            nxt = m_pred(m_pc);
            if (bus.halt || m_halted) begin
                m_halted = 1'b1;
                m_fv     = 1'b0;
            end else begin
                if (bus.redirect) m_pc = bus.redirect_pc;
                else if (!bus.stall && m_fv) m_pc = nxt;
                m_fv = 1'b1;
            end
            if (bus.upd_en) begin
                ix = int'(bus.upd_pc[10:1]);
                if (m_hit(bus.upd_pc)) begin
                    if (bus.upd_taken) begin
                        m_ctr[ix] = (m_ctr[ix] + 1 > 3) ? 3 : m_ctr[ix] + 1;
                        m_tgt[ix] = bus.upd_target;
                    end else begin
                        m_ctr[ix] = (m_ctr[ix] - 1 < 0) ? 0 : m_ctr[ix] - 1;
                    end
                end else if (bus.upd_taken) begin
                    m_valid[ix] = 1'b1;
                    m_tag[ix]   = int'(bus.upd_pc[15:11]);
                    m_tgt[ix]   = bus.upd_target;
                    m_ctr[ix]   = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("model_fetch_valid", 16'(bus.fetch_valid), 16'(m_fv));
            check("model_fetch_pc", bus.fetch_pc, m_pc);
            check("model_pred_taken", 16'(bus.pred_taken), 16'(m_ptaken(m_pc)));
            check("model_pred_next", bus.pred_next, m_pred(m_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.halt = 0; bus.redirect = 0; bus.redirect_pc = 16'h0;
        bus.upd_en = 0; bus.upd_pc = 16'h0; bus.upd_taken = 0; bus.upd_target = 16'h0;
    endtask

    task automatic redirect_to(input logic [15:0] a);
        bus.redirect = 1; bus.redirect_pc = a;
        tick();
        bus.redirect = 0;
    endtask

    task automatic train(input logic [15:0] a, input logic tk, input logic [15:0] tg);
        bus.upd_en = 1; bus.upd_pc = a; bus.upd_taken = tk; bus.upd_target = tg;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        check("rst_fetch_valid", 16'(bus.fetch_valid), 16'h0);
        check("rst_fetch_pc", bus.fetch_pc, 16'h0000);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_fetch_valid", 16'(bus.fetch_valid), 16'h1);
            check("seq_fetch_pc", bus.fetch_pc, 16'(k * 2));
            check("seq_pred_taken", 16'(bus.pred_taken), 16'h0);
        end

        train(16'h0006, 1'b1, 16'h0020);
        redirect_to(16'h0000);
        bus.upd_en = 0;
        tick(); tick(); tick();
        check("train_pc", bus.fetch_pc, 16'h0006);
        check("train_pred_taken", 16'(bus.pred_taken), 16'h1);
        check("train_pred_next", bus.pred_next, 16'h0020);
        tick();
        check("train_follow", bus.fetch_pc, 16'h0020);

        train(16'h0006, 1'b0, 16'h0000);
        redirect_to(16'h0000);
        tick();
        bus.upd_en = 0;
        tick(); tick();
        check("decay_pc", bus.fetch_pc, 16'h0006);
        check("decay_pred_taken", 16'(bus.pred_taken), 16'h0);
        check("decay_pred_next", bus.pred_next, 16'h0008);
        train(16'h0006, 1'b1, 16'h0020);
        tick();
        bus.upd_en = 0;
        redirect_to(16'h0006);
        check("weak_pred_taken", 16'(bus.pred_taken), 16'h0);
        check("weak_pred_next", bus.pred_next, 16'h0008);

        train(16'h0006, 1'b1, 16'h0020);
        redirect_to(16'h0806);
        bus.upd_en = 0;
        check("alias_pred_taken", 16'(bus.pred_taken), 16'h0);
        check("alias_pred_next", bus.pred_next, 16'h0808);
        redirect_to(16'h0006);
        check("retrain_pred_next", bus.pred_next, 16'h0020);

        bus.stall = 1;
        redirect_to(16'h0100);
        check("redir_over_stall", bus.fetch_pc, 16'h0100);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", bus.fetch_pc, 16'h0100);
        end
        bus.stall = 0;

        redirect_to(16'hfffe);
        check("wrap_pc", bus.fetch_pc, 16'hfffe);
        check("wrap_pred_next", bus.pred_next, 16'h0000);
        tick();
        check("wrap_follow", bus.fetch_pc, 16'h0000);

        bus.halt = 1;
        tick();
        bus.halt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("halt_fetch_valid", 16'(bus.fetch_valid), 16'h0);
            check("halt_fetch_pc", bus.fetch_pc, 16'h0000);
        end

        train(16'h0006, 1'b1, 16'h0020);
        redirect_to(16'h0040);
        bus.upd_en = 0;
        rst = 1;
        tick();
        rst = 0;
        check("midrst_pc", bus.fetch_pc, 16'h0000);
        check("midrst_fetch_valid", 16'(bus.fetch_valid), 16'h0);
        tick();
        redirect_to(16'h0006);
        check("midrst_miss", 16'(bus.pred_taken), 16'h0);
        check("midrst_pred_next", bus.pred_next, 16'h0008);

        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 399) == 0);
            bus.halt        = ($urandom_range(0, 299) == 0);
            bus.redirect    = ($urandom_range(0, 7) == 0);
            bus.redirect_pc = 16'($urandom_range(0, 40) * 2) | (($urandom_range(0, 3) == 0) ? 16'h0800 : 16'h0000);
            bus.stall       = ($urandom_range(0, 5) == 0);
            bus.upd_en      = ($urandom_range(0, 2) == 0);
            bus.upd_pc      = 16'(($urandom_range(0, 15) << 1) | ($urandom_range(0, 1) << 11));
            bus.upd_taken   = ($urandom_range(0, 2) != 0);
            bus.upd_target  = 16'($urandom_range(0, 40) * 2);
            if (m_halted && $urandom_range(0, 7) == 0) rst = 1;
            tick();
        end
        rst = 0;
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
